pe_row_sequencer: RTL
=====================

Name: pe_row_sequencer

Overview:
- Initiator side of the PE dot-product protocol: drives one PE through M rows of a mat-vec product.
- Per row: selects the row (row_idx), pulses pe_valid, waits for pe_done, captures pe_y with its row index into a result FIFO.
- Results leave on a valid/ready stream toward the output vector writer.
- Sits between the top-level controller (start/done) and the PE plus its row-storage mux.

Parameters:
- N, 786, PE vector length; sets the expected done latency.
- DW, 16, PE operand width; result width is 2*DW.
- M_MAX, 1024, maximum rows per job.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- SLACK, 4, extra cycles beyond N before a missing pe_done is an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  job start pulse; sampled only in IDLE
- num_rows  in  $clog2(M_MAX+1)  rows in the job; captured on start
- busy  out  1  high from accepted start until job end
- done  out  1  one-cycle pulse when the last result is written to the FIFO
- err  out  1  sticky timeout flag; cleared on accepted start or rst
- row_idx  out  $clog2(M_MAX)  row select to the PE row mux; stable from ISSUE through WAIT
- pe_valid  out  1  one-cycle PE restart pulse
- pe_y  in  2*DW  PE result, signed
- pe_done  in  1  PE result strobe
- out_data  out  2*DW  FIFO head result
- out_idx  out  $clog2(M_MAX)  row index of the FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accept

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0. FIFO empty, FSM in IDLE, counters 0.
- IDLE:
  - start=1 -> latch num_rows, set row_idx=0, clear err, set busy=1.
  - If num_rows==0 -> DONE. Otherwise -> ISSUE.
- ISSUE:
  - Wait while FIFO count==FIFO_DEPTH; no issue without a reserved slot. Only one row is ever in flight.
  - When space exists, assert pe_valid for exactly one cycle, clear the wait counter -> WAIT.
- WAIT:
  - Wait counter increments each cycle. pe_valid stays 0, because any pe_valid re-restarts the PE.
  - Nominal PE response is pe_done N cycles after the pe_valid edge.
  - pe_done=1: push {row_idx, pe_y} into the FIFO the same cycle.
    - If row_idx==num_rows-1 -> DONE.
    - Otherwise increment row_idx -> ISSUE.
  - Counter reaches N+SLACK without pe_done: set err=1, push nothing -> IDLE with busy=0 and no done pulse.
- DONE: done=1 for one cycle, busy=0 -> IDLE. The FIFO may still hold undrained results; they keep draining.
- pe_done outside WAIT is ignored. The PE raises a spurious done N cycles after reset; it must not be captured.
- FIFO:
  - Synchronous; pop when out_valid && out_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Output is first-word-fall-through: out_data/out_idx are valid combinationally with out_valid.
- start while busy is ignored. A new job may start while the FIFO still holds results of the previous job; ordering is preserved.
- No arithmetic on pe_y; it is passed through bit-exact, signed.
- rst mid-job: immediate abort, FIFO flushed, no done.

Decomposition:
- pe_pkg holds:
  - DW and N defaults
  - typedef for the result word (signed [2*DW-1:0])
  - FSM state enum {IDLE, ISSUE, WAIT, DONE}
- Sub-module result_fifo (parameters WIDTH, DEPTH) stores {idx, data}. The FSM stays in pe_row_sequencer.

Test Plan:
- Basic job: N=4, num_rows=3, behavioural PE returning y=100+row, out_ready=1.
  - Required: pe_valid pulses exactly 3 times, each 5 cycles apart (1 ISSUE + 4 WAIT).
  - Required: out stream (0,100),(1,101),(2,102); done pulse on the third push cycle.
- Backpressure: N=4, num_rows=8, FIFO_DEPTH=4, out_ready=0.
  - Required: exactly 4 pe_valid pulses, then the FSM holds in ISSUE.
  - Then raise out_ready=1. Required: remaining 4 rows issue, 8 results arrive in order, one done.
- Empty job: num_rows=0, then start. Required: done one cycle later, pe_valid never asserted, out_valid=0.
- Timeout: PE model never asserts pe_done, SLACK=4. Required: err=1 and busy=0 at 8 cycles after pe_valid; no done; FIFO stays empty.
- Spurious and ignored inputs:
  - pe_done pulse injected in IDLE after reset -> no FIFO push.
  - start asserted during WAIT -> ignored; num_rows is not re-latched.
- Reset mid-job: num_rows=5, assert rst during WAIT of row 2. Required: all outputs 0, out_valid=0. A subsequent job with num_rows=2 completes normally with idx 0,1.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the PE row sequencer: default PE geometry, the result word
// and the sequencer FSM state encoding.
package pe_pkg;

    localparam int DW_DEF = 16;
    localparam int N_DEF  = 786;

    typedef logic signed [2*DW_DEF-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO holding {row index, PE result} words
// on their way to the output vector writer.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    // Head is forced to zero when empty so the output bus is quiet after a flush.
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/pe_row_sequencer.sv
// Drives one PE through the rows of a mat-vec job, one row in flight at a time,
// and queues each result with its row index on a valid/ready stream.
module pe_row_sequencer
    import pe_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DW         = DW_DEF,
    parameter int M_MAX      = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int SLACK      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(M_MAX+1)-1:0]   num_rows,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(M_MAX)-1:0]     row_idx,
    output logic                         pe_valid,
    input  logic signed [2*DW-1:0]       pe_y,
    input  logic                         pe_done,
    output logic signed [2*DW-1:0]       out_data,
    output logic [$clog2(M_MAX)-1:0]     out_idx,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int IW = $clog2(M_MAX);
    localparam int CW = $clog2(M_MAX + 1);
    localparam int WW = $clog2(N + SLACK + 1);
    localparam int FW = IW + 2*DW;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   num_rows_r;
    logic [CW-1:0]   num_rows_next_s;
    logic [IW-1:0]   row_idx_r;
    logic [IW-1:0]   row_idx_next_s;
    logic [WW-1:0]   wait_cnt_r;
    logic [WW-1:0]   wait_cnt_next_s;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            err_next_s;
    logic            pe_valid_s;
    logic            fifo_push_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [FW-1:0]   fifo_head_s;
    logic            last_row_s;
    logic            timeout_s;

    assign last_row_s = ((CW'(row_idx_r) + CW'(1)) == num_rows_r);
    // Fires on the last WAIT cycle before the counter would reach N+SLACK.
    assign timeout_s  = (wait_cnt_r == WW'(N + SLACK - 1));

    // Next-state and datapath control for the row issue/wait loop.
    always_comb begin
        state_next_s    = state_r;
        num_rows_next_s = num_rows_r;
        row_idx_next_s  = row_idx_r;
        wait_cnt_next_s = wait_cnt_r;
        err_next_s      = err_r;
        pe_valid_s      = 1'b0;
        fifo_push_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    num_rows_next_s = num_rows;
                    row_idx_next_s  = {IW{1'b0}};
                    err_next_s      = 1'b0;
                    if (num_rows == CW'(0)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (!fifo_full_s) begin
                    pe_valid_s      = 1'b1;
                    wait_cnt_next_s = WW'(1);
                    state_next_s    = WAIT;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT: begin
                if (pe_done) begin
                    fifo_push_s = 1'b1;
                    if (last_row_s) begin
                        state_next_s = DONE;
                    end else begin
                        row_idx_next_s = row_idx_r + IW'(1);
                        state_next_s   = ISSUE;
                    end
                end else if (timeout_s) begin
                    err_next_s   = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WW'(1);
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, job registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            num_rows_r <= {CW{1'b0}};
            row_idx_r  <= {IW{1'b0}};
            wait_cnt_r <= {WW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            num_rows_r <= num_rows_next_s;
            row_idx_r  <= row_idx_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            busy_r     <= (state_next_s == ISSUE) || (state_next_s == WAIT);
            done_r     <= (state_next_s == DONE);
            err_r      <= err_next_s;
        end
    end

    result_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data ({row_idx_r, pe_y}),
        .pop       (out_valid && out_ready),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign row_idx   = row_idx_r;
    assign pe_valid  = pe_valid_s;
    assign out_valid = !fifo_empty_s;
    assign out_idx   = fifo_head_s[FW-1 -: IW];
    assign out_data  = $signed(fifo_head_s[2*DW-1:0]);

endmodule
